// File: rtl/sfif_rx_fifo.sv
// -----------------------------------------------------------------------------
// sfif_rx_fifo
//   Receive-side TLP buffer between the PCIe core RX interface (64-bit beats)
//   and the 32-bit SFIF consumer. Whole TLPs are buffered; a TLP becomes
//   visible to the reader only once its end beat is stored (commit). A TLP
//   that does not fit is dropped in its entirety. The read side presents a
//   show-ahead 32-bit dword stream with start/end flags.
//
// Ports
//   clk_125    in   clock
//   rstn       in   async active-low reset
//   rprst      in   sync clear of pointers, flags, counters, output register
//   rx_st      in   first beat of TLP (with rx_val)
//   rx_end     in   last beat of TLP (with rx_val)
//   rx_dwen    in   with rx_end: only rx_data[63:32] carries data
//   rx_val     in   beat valid
//   rx_data    in   beat data, [63:32] is the earlier dword
//   rx32_data  out  current output dword
//   rx32_st    out  current dword is first of a TLP
//   rx32_end   out  current dword is last of a TLP
//   rx32_dv    out  rx32_* valid
//   rx32_rd    in   pop current dword
//   empty      out  no committed beat left to read
//   overflow   out  sticky: a TLP was dropped for lack of space
//   seq_err    out  sticky: rx_st seen inside a TLP
//   tlp_cnt    out  committed TLP count (wraps)
//
// Write FSM
//   state  | meaning
//   S_IDLE | between TLPs, waiting for a beat with rx_st
//   S_PKT  | storing beats of an accepted TLP, not yet committed
//   S_DROP | discarding the rest of a TLP that overflowed
// -----------------------------------------------------------------------------
module sfif_rx_fifo #(
  parameter int ADDR_W = 9
) (
  input  logic        clk_125,
  input  logic        rstn,
  input  logic        rprst,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic        rx_dwen,
  input  logic        rx_val,
  input  logic [63:0] rx_data,
  output logic [31:0] rx32_data,
  output logic        rx32_st,
  output logic        rx32_end,
  output logic        rx32_dv,
  input  logic        rx32_rd,
  output logic        empty,
  output logic        overflow,
  output logic        seq_err,
  output logic [15:0] tlp_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int ENT_W = 67;  // {dwen, end, st, data[63:0]}
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } wr_state_t;

  wr_state_t         r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_wr_commit;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_fetch_ptr;
  logic              r_overflow;
  logic              r_seq_err;
  logic [15:0]       r_tlp_cnt;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ENT_W-1:0]  r_q;
  logic              r_q_vld;
  logic [ENT_W-1:0]  r_out;
  logic              r_dv;
  logic              r_h;

  logic              w_restart;
  logic [ADDR_W:0]   w_base;
  logic              w_full;
  logic              w_take;
  logic              w_mem_we;
  logic [ENT_W-1:0]  w_wr_entry;
  logic              w_pop;
  logic              w_pop_last;
  logic              w_load_out;
  logic              w_fetch;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // rx_st inside a TLP restarts from the last commit point, so the new TLP is
  // placed (and checked for space) as if the partial one never existed.
  assign w_restart  = (r_state == S_PKT) && rx_st;
  assign w_base     = w_restart ? r_wr_commit : r_wr_ptr;
  assign w_full     = (w_base - r_rd_ptr) == C_DEPTH;
  assign w_take     = rx_val && (rx_st || (r_state == S_PKT));
  assign w_mem_we   = w_take && !w_full && !rprst;
  assign w_wr_entry = {rx_dwen & rx_end, rx_end, rx_st, rx_data};

  always_ff @(posedge clk_125) begin
    if (w_mem_we) begin
      r_mem[w_base[ADDR_W-1:0]] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_overflow  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_tlp_cnt   <= '0;
    end else if (rprst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_overflow  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_tlp_cnt   <= '0;
    end else if (rx_val) begin
      if (w_restart) begin
        r_seq_err <= 1'b1;
      end
      if (w_take) begin
        if (w_full) begin
          // Roll back whatever part of this TLP was already written.
          r_wr_ptr   <= r_wr_commit;
          r_overflow <= 1'b1;
          r_state    <= rx_end ? S_IDLE : S_DROP;
        end else begin
          r_wr_ptr <= w_base + C_ONE;
          if (rx_end) begin
            r_wr_commit <= w_base + C_ONE;
            r_tlp_cnt   <= r_tlp_cnt + 16'd1;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_PKT;
          end
        end
      end else if ((r_state == S_DROP) && rx_end) begin
        r_state <= S_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: RAM read register (r_q) feeding the output entry (r_out).
  // r_q runs one entry ahead of r_out so a pop of the last half of an entry
  // can be followed immediately by the next entry.
  // rd_ptr only advances when an entry is fully consumed, so space held by
  // prefetched entries is never handed back to the writer early.
  // ---------------------------------------------------------------------------
  assign w_pop      = r_dv && rx32_rd;
  assign w_pop_last = w_pop && (r_h || (r_out[65] && r_out[66]));
  assign w_load_out = (!r_dv || w_pop_last) && r_q_vld;
  assign w_fetch    = (r_fetch_ptr != r_wr_commit) && (!r_q_vld || w_load_out);

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_q         <= '0;
      r_q_vld     <= 1'b0;
      r_out       <= '0;
      r_dv        <= 1'b0;
      r_h         <= 1'b0;
    end else if (rprst) begin
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_q         <= '0;
      r_q_vld     <= 1'b0;
      r_out       <= '0;
      r_dv        <= 1'b0;
      r_h         <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_q         <= r_mem[r_fetch_ptr[ADDR_W-1:0]];
        r_fetch_ptr <= r_fetch_ptr + C_ONE;
      end
      r_q_vld <= w_fetch || (r_q_vld && !w_load_out);

      if (w_load_out) begin
        r_out <= r_q;
        r_dv  <= 1'b1;
      end else if (w_pop_last) begin
        r_dv  <= 1'b0;
      end

      if (w_pop_last) begin
        r_h      <= 1'b0;
        r_rd_ptr <= r_rd_ptr + C_ONE;
      end else if (w_pop) begin
        r_h      <= 1'b1;
      end
    end
  end

  assign rx32_data = r_h ? r_out[31:0] : r_out[63:32];
  assign rx32_st   = r_dv && r_out[64] && !r_h;
  assign rx32_end  = r_dv && r_out[65] && (r_h || r_out[66]);
  assign rx32_dv   = r_dv;
  assign empty     = (r_rd_ptr == r_wr_commit);
  assign overflow  = r_overflow;
  assign seq_err   = r_seq_err;
  assign tlp_cnt   = r_tlp_cnt;

endmodule

// File: tb/tb_sfif_rx_fifo.sv
module tb_sfif_rx_fifo;

  logic        clk_125 = 1'b0;
  logic        rstn    = 1'b0;
  logic        rprst   = 1'b0;
  logic        rx_st   = 1'b0;
  logic        rx_end  = 1'b0;
  logic        rx_dwen = 1'b0;
  logic        rx_val  = 1'b0;
  logic [63:0] rx_data = '0;
  logic        rx32_rd = 1'b0;

  // large instance (default depth) and small instance (depth 4)
  logic [31:0] data_b, data_s;
  logic        st_b, st_s, end_b, end_s, dv_b, dv_s;
  logic        empty_b, empty_s, ovf_b, ovf_s, serr_b, serr_s;
  logic [15:0] cnt_b, cnt_s;

  logic        sel = 1'b0;
  logic [31:0] m_data;
  logic        m_st, m_end, m_dv, m_empty, m_ovf, m_serr;
  logic [15:0] m_cnt;

  assign m_data  = sel ? data_s  : data_b;
  assign m_st    = sel ? st_s    : st_b;
  assign m_end   = sel ? end_s   : end_b;
  assign m_dv    = sel ? dv_s    : dv_b;
  assign m_empty = sel ? empty_s : empty_b;
  assign m_ovf   = sel ? ovf_s   : ovf_b;
  assign m_serr  = sel ? serr_s  : serr_b;
  assign m_cnt   = sel ? cnt_s   : cnt_b;

  sfif_rx_fifo u_dut_big (
    .clk_125(clk_125), .rstn(rstn), .rprst(rprst),
    .rx_st(rx_st), .rx_end(rx_end), .rx_dwen(rx_dwen), .rx_val(rx_val), .rx_data(rx_data),
    .rx32_data(data_b), .rx32_st(st_b), .rx32_end(end_b), .rx32_dv(dv_b), .rx32_rd(rx32_rd),
    .empty(empty_b), .overflow(ovf_b), .seq_err(serr_b), .tlp_cnt(cnt_b)
  );

  sfif_rx_fifo #(.ADDR_W(2)) u_dut_small (
    .clk_125(clk_125), .rstn(rstn), .rprst(rprst),
    .rx_st(rx_st), .rx_end(rx_end), .rx_dwen(rx_dwen), .rx_val(rx_val), .rx_data(rx_data),
    .rx32_data(data_s), .rx32_st(st_s), .rx32_end(end_s), .rx32_dv(dv_s), .rx32_rd(rx32_rd),
    .empty(empty_s), .overflow(ovf_s), .seq_err(serr_s), .tlp_cnt(cnt_s)
  );

  always #5 clk_125 = ~clk_125;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int pop_first = 0;
  int pop_last  = 0;

  // expected word: {st, end, data}
  logic [33:0] exp_q[$];

  always @(posedge clk_125) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic st, input logic en);
    exp_q.push_back({st, en, d});
  endtask

  // monitor: every word the consumer pops is compared against the scoreboard
  always @(negedge clk_125) begin
    if (rstn && !rprst && m_dv && rx32_rd) begin
      if (pop_cnt == 0) pop_first = cyc;
      pop_last = cyc;
      pop_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word actual st=%0b end=%0b data=%h expected none",
                 m_st, m_end, m_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({m_st, m_end, m_data} !== e) begin
          n_fail++;
          $display("FAIL word actual st=%0b end=%0b data=%h expected st=%0b end=%0b data=%h",
                   m_st, m_end, m_data, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  task automatic beat(input logic st, input logic en, input logic dwen, input logic [63:0] d);
    rx_val  = 1'b1;
    rx_st   = st;
    rx_end  = en;
    rx_dwen = dwen;
    rx_data = d;
    @(posedge clk_125);
    #1;
    rx_val  = 1'b0;
    rx_st   = 1'b0;
    rx_end  = 1'b0;
    rx_dwen = 1'b0;
  endtask

  task automatic do_rprst();
    rprst = 1'b1;
    @(posedge clk_125);
    #1;
    rprst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_125);
      if (exp_q.size() == 0 && !m_dv) done = 1'b1;
    end
    check({name, "_drain_done"}, {63'd0, done}, 64'd1);
    exp_q.delete();
  endtask

  task automatic wait_dv(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_125);
      if (m_dv) done = 1'b1;
    end
    check({name, "_dv_seen"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_125);
    #1;
    rstn = 1'b1;

    // reset state
    @(negedge clk_125);
    check("rst_dv",      {63'd0, m_dv},    64'd0);
    check("rst_empty",   {63'd0, m_empty}, 64'd1);
    check("rst_cnt",     {48'd0, m_cnt},   64'd0);
    check("rst_ovf",     {63'd0, m_ovf},   64'd0);
    check("rst_serr",    {63'd0, m_serr},  64'd0);
    check("rst_data",    {32'd0, m_data},  64'd0);
    @(posedge clk_125);
    #1;

    // 3-DW TLP with dwen end beat, plus commit-to-dv latency
    push_exp(32'hA1A1_A1A1, 1'b1, 1'b0);
    push_exp(32'hA0A0_A0A0, 1'b0, 1'b0);
    push_exp(32'hB1B1_B1B1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 64'hA1A1_A1A1_A0A0_A0A0);
    beat(1'b0, 1'b1, 1'b1, 64'hB1B1_B1B1_DEAD_BEEF);
    @(negedge clk_125);
    @(negedge clk_125);
    check("lat_edge1_dv", {63'd0, m_dv}, 64'd0);
    @(negedge clk_125);
    check("lat_edge2_dv", {63'd0, m_dv}, 64'd1);
    check("dw3_cnt", {48'd0, m_cnt}, 64'd1);
    @(posedge clk_125);
    #1;
    rx32_rd = 1'b1;
    wait_drain("dw3");
    check("dw3_empty", {63'd0, m_empty}, 64'd1);

    // backpressure: 4-beat TLP held for 10 cycles
    @(posedge clk_125);
    #1;
    rx32_rd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] hi, lo;
      hi = 32'hC000_0000 + 32'(2 * k);
      lo = hi + 32'd1;
      push_exp(hi, k == 0, 1'b0);
      push_exp(lo, 1'b0, k == 3);
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] hi;
      hi = 32'hC000_0000 + 32'(2 * k);
      beat(k == 0, k == 3, 1'b0, {hi, hi + 32'd1});
    end
    wait_dv("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_125);
      check("bp_hold", {31'd0, m_dv, m_data}, {31'd0, 1'b1, 32'hC000_0000});
    end
    @(posedge clk_125);
    #1;
    rx32_rd = 1'b1;
    wait_drain("bp");
    check("bp_cnt", {48'd0, m_cnt}, 64'd2);

    // sequence error: partial D TLP discarded, E TLP delivered
    do_rprst();
    push_exp(32'hE000_0000, 1'b1, 1'b0);
    push_exp(32'hE000_0001, 1'b0, 1'b0);
    push_exp(32'hE000_0002, 1'b0, 1'b0);
    push_exp(32'hE000_0003, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 64'hD000_0000_D000_0001);
    beat(1'b1, 1'b0, 1'b0, 64'hE000_0000_E000_0001);
    beat(1'b0, 1'b1, 1'b0, 64'hE000_0002_E000_0003);
    wait_drain("seq");
    check("seq_serr", {63'd0, m_serr}, 64'd1);
    check("seq_cnt",  {48'd0, m_cnt},  64'd1);
    check("seq_ovf",  {63'd0, m_ovf},  64'd0);

    // overflow on the depth-4 instance
    sel = 1'b1;
    rx32_rd = 1'b0;
    do_rprst();
    for (int k = 0; k < 6; k++) begin
      beat(k == 0, k == 5, 1'b0, {32'hF000_0000 + 32'(k), 32'hF100_0000 + 32'(k)});
    end
    @(negedge clk_125);
    check("ovf_flag",  {63'd0, m_ovf},   64'd1);
    check("ovf_empty", {63'd0, m_empty}, 64'd1);
    check("ovf_cnt",   {48'd0, m_cnt},   64'd0);
    repeat (3) @(negedge clk_125);
    check("ovf_no_dv", {63'd0, m_dv},    64'd0);
    @(posedge clk_125);
    #1;
    push_exp(32'h6000_0000, 1'b1, 1'b0);
    push_exp(32'h6000_0001, 1'b0, 1'b0);
    push_exp(32'h6000_0002, 1'b0, 1'b0);
    push_exp(32'h6000_0003, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0, 64'h6000_0000_6000_0001);
    beat(1'b0, 1'b1, 1'b0, 64'h6000_0002_6000_0003);
    rx32_rd = 1'b1;
    wait_drain("ovf_next");
    check("ovf_next_cnt", {48'd0, m_cnt}, 64'd1);

    // rprst while a TLP is mid-output
    @(posedge clk_125);
    #1;
    rx32_rd = 1'b0;
    push_exp(32'h7000_0000, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 64'h7000_0000_7000_0001);
    beat(1'b0, 1'b0, 1'b0, 64'h7000_0002_7000_0003);
    beat(1'b0, 1'b1, 1'b0, 64'h7000_0004_7000_0005);
    wait_dv("rp");
    @(posedge clk_125);
    #1;
    rx32_rd = 1'b1;
    @(posedge clk_125);
    #1;
    rx32_rd = 1'b0;
    check("rp_pre_dv", {63'd0, m_dv}, 64'd1);
    do_rprst();
    @(negedge clk_125);
    check("rp_dv",    {63'd0, m_dv},    64'd0);
    check("rp_empty", {63'd0, m_empty}, 64'd1);
    check("rp_cnt",   {48'd0, m_cnt},   64'd0);
    check("rp_ovf",   {63'd0, m_ovf},   64'd0);
    check("rp_left",  64'(exp_q.size()), 64'd0);

    // stream: 4 back-to-back 3-beat TLPs, continuous reads
    sel = 1'b0;
    @(posedge clk_125);
    #1;
    do_rprst();
    pop_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 3; b++) begin
        logic [31:0] w;
        w = 32'h5000_0000 | 32'(t << 8) | 32'(b << 4);
        push_exp(w, b == 0, 1'b0);
        push_exp(w | 32'd1, 1'b0, b == 2);
      end
    end
    rx32_rd = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 3; b++) begin
        logic [31:0] w;
        w = 32'h5000_0000 | 32'(t << 8) | 32'(b << 4);
        beat(b == 0, b == 2, 1'b0, {w, w | 32'd1});
      end
    end
    wait_drain("stream");
    check("stream_words", 64'(pop_cnt), 64'd24);
    check("stream_gapless", 64'(pop_last - pop_first), 64'd23);
    check("stream_cnt", {48'd0, m_cnt}, 64'd4);
    check("stream_empty", {63'd0, m_empty}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
